// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative radix-2 Booth
// multiply and signed restoring divide, with a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cntrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C_LO,
    output logic [WIDTH-1:0] C_HI,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic [1:0]       o_dbg_state
);

    // Handshake: start is accepted only in a cycle where busy=0 (including the
    // done cycle); done is a one-cycle pulse and the C_*/flag outputs hold until the next done.

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_NEG = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    localparam logic [3:0] OP_SHR = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_m;
    logic             r_qm1;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [SHW-1:0]          w_sh;
    logic signed [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0]        w_alu;
    logic [WIDTH-1:0]        w_abs_a;
    logic [WIDTH-1:0]        w_abs_b;
    logic [WIDTH:0]          w_bsum;
    logic [WIDTH:0]          w_bacc;
    logic [WIDTH-1:0]        w_bq;
    logic [WIDTH:0]          w_dshift;
    logic [WIDTH:0]          w_ddiff;
    logic [WIDTH:0]          w_drem;
    logic [WIDTH-1:0]        w_dq;

    assign o_dbg_state = r_state;
    assign w_sh        = B[SHW-1:0];
    assign w_sra       = $signed(A) >>> w_sh;
    assign w_abs_a     = A[WIDTH-1] ? -A : A;
    assign w_abs_b     = B[WIDTH-1] ? -B : B;

    always_comb begin
        w_alu = '0;
        case (cntrl)
            OP_AND: w_alu = A & B;
            OP_OR:  w_alu = A | B;
            OP_ADD: w_alu = A + B;
            OP_SUB: w_alu = A - B;
            OP_NEG: w_alu = -B;
            OP_NOT: w_alu = ~B;
            OP_SHL: w_alu = A << w_sh;
            OP_SRA: w_alu = w_sra;
            OP_ROL: w_alu = (A << w_sh) | (A >> (WIDTH - int'(w_sh)));
            OP_ROR: w_alu = (A >> w_sh) | (A << (WIDTH - int'(w_sh)));
            OP_SHR: w_alu = A >> w_sh;
            default: w_alu = '0;
        endcase
    end

    // Booth step; the extra accumulator bit keeps acc-M exact when M is most-negative.
    always_comb begin
        w_bsum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_bsum = r_acc + r_m;
            2'b10:   w_bsum = r_acc - r_m;
            default: w_bsum = r_acc;
        endcase
        w_bacc = {w_bsum[WIDTH], w_bsum[WIDTH:1]};
        w_bq   = {w_bsum[0], r_q[WIDTH-1:1]};
    end

    // Restoring divide step on magnitudes: r_acc is the partial remainder, r_q the dividend/quotient.
    always_comb begin
        w_dshift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_ddiff  = w_dshift - r_m;
        w_drem   = w_ddiff[WIDTH] ? w_dshift : w_ddiff;
        w_dq     = {r_q[WIDTH-2:0], ~w_ddiff[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_qm1       <= 1'b0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            C_LO        <= '0;
            C_HI        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
                        case (cntrl)
                            OP_MUL: begin
                                r_acc   <= '0;
                                r_q     <= A;
                                r_qm1   <= 1'b0;
                                r_m     <= {B[WIDTH-1], B};
                                r_cnt   <= CW'(WIDTH - 1);
                                busy    <= 1'b1;
                                r_state <= S_MUL;
                            end
                            OP_DIV: begin
                                if (B == '0) begin
                                    C_LO        <= '1;
                                    C_HI        <= A;
                                    div_by_zero <= 1'b1;
                                    done        <= 1'b1;
                                end else begin
                                    r_acc   <= '0;
                                    r_q     <= w_abs_a;
                                    r_m     <= {1'b0, w_abs_b};
                                    r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                                    r_neg_r <= A[WIDTH-1];
                                    r_cnt   <= CW'(WIDTH - 1);
                                    busy    <= 1'b1;
                                    r_state <= S_DIV;
                                end
                            end
                            4'd13, 4'd14, 4'd15: begin
                                C_LO       <= '0;
                                C_HI       <= '0;
                                illegal_op <= 1'b1;
                                done       <= 1'b1;
                            end
                            default: begin
                                C_LO <= w_alu;
                                C_HI <= '0;
                                done <= 1'b1;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= w_bacc;
                    r_q   <= w_bq;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        C_HI    <= w_bacc[WIDTH-1:0];
                        C_LO    <= w_bq;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_drem;
                    r_q   <= w_dq;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    C_LO    <= r_neg_q ? -r_q : r_q;
                    C_HI    <= r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed corner cases plus randomized ops against a
// plain-arithmetic reference model, checked by a done-driven scoreboard monitor.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, start;
  logic [3:0] cntrl;
  logic [W-1:0] a, b;
  logic [W-1:0] c_lo, c_hi;
  logic busy, done, div_by_zero, illegal_op;
  logic [1:0] dbg_state;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .cntrl(cntrl), .A(a), .B(b),
    .C_LO(c_lo), .C_HI(c_hi), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op), .o_dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int op;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic dbz;
    logic ill;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // reference model: direct arithmetic on 64-bit signed values
  function automatic exp_t model(int op, logic [W-1:0] x, logic [W-1:0] y);
    exp_t e;
    longint sx, sy, p, q, r;
    int sh;
    e.op = op; e.lo = '0; e.hi = '0; e.dbz = 1'b0; e.ill = 1'b0; e.due = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    case (op)
      0: e.lo = x & y;
      1: e.lo = x | y;
      2: e.lo = x + y;
      3: e.lo = x - y;
      4: e.lo = 32'd0 - y;
      5: e.lo = ~y;
      6: e.lo = x << sh;
      7: e.lo = 32'(sx >>> sh);
      8: e.lo = (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
      9: e.lo = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
      12: e.lo = x >> sh;
      10: begin
        p = sx * sy;
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      11: begin
        if (y == 0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = x;
          e.dbz = 1'b1;
        end else begin
          q = sx / sy;
          r = sx % sy;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic int latency(int op, logic [W-1:0] y);
    if (op == 10) return W + 1;
    if (op == 11 && y != 0) return W + 2;
    return 1;
  endfunction

  // driver: called at a negedge; holds start for one cycle then scrambles operands
  task automatic issue(int op, logic [W-1:0] x, logic [W-1:0] y, bit track);
    exp_t e;
    start = 1'b1;
    cntrl = op[3:0];
    a = x;
    b = y;
    if (track) begin
      e = model(op, x, y);
      e.due = cyc + latency(op, y);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    cntrl = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'h7FFF_FFFF;
      5: return 32'd32;
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("op%0d C_LO", mon_e.op), 64'(c_lo), 64'(mon_e.lo));
        chk($sformatf("op%0d C_HI", mon_e.op), 64'(c_hi), 64'(mon_e.hi));
        chk($sformatf("op%0d div_by_zero", mon_e.op), 64'(div_by_zero), 64'(mon_e.dbz));
        chk($sformatf("op%0d illegal_op", mon_e.op), 64'(illegal_op), 64'(mon_e.ill));
        chk($sformatf("op%0d done_cycle", mon_e.op), 64'(cyc), 64'(mon_e.due));
        chk($sformatf("op%0d busy_in_done", mon_e.op), 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int op;
    reset = 1'b1; start = 1'b0; cntrl = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset C_LO", 64'(c_lo), 64'd0);
    chk("reset C_HI", 64'(c_hi), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    chk("reset illegal_op", 64'(illegal_op), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed cases
    issue(10, 32'hFFFF_FFF9, 32'd3, 1); drain();
    issue(11, 32'hFFFF_FFF9, 32'd2, 1); drain();
    issue(11, 32'd7, 32'hFFFF_FFFE, 1); drain();
    issue(11, 32'd5, 32'd0, 1); drain();
    issue(2, 32'd2, 32'd3, 1); drain();
    issue(8, 32'h8000_0001, 32'd4, 1); drain();
    issue(9, 32'd1, 32'd1, 1); drain();
    issue(7, 32'h8000_0000, 32'd31, 1); drain();
    issue(6, 32'h1234_5678, 32'd32, 1); drain();
    issue(10, 32'h8000_0000, 32'h8000_0000, 1); drain();
    issue(11, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain();
    issue(14, 32'h1, 32'h2, 1); drain();

    // start while busy must be ignored
    issue(10, 32'd12345, 32'hFFFF_FF00, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; cntrl = 4'd11; a = 32'd99; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-divide aborts with no done
    issue(11, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort C_LO", 64'(c_lo), 64'd0);
    chk("abort C_HI", 64'(c_hi), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    issue(2, 32'd10, 32'd20, 1); drain();

    // reset beats start
    reset = 1'b1; start = 1'b1; cntrl = 4'd2; a = 32'd2; b = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_vs_start C_LO", 64'(c_lo), 64'd0);
    chk("reset_vs_start done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);

    // back-to-back: ADD issued in the MUL done cycle
    issue(10, 32'hFFFF_FFF9, 32'd3, 1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b wait_done", 64'(done), 64'd1);
    issue(2, 32'd40, 32'd2, 1);
    drain();

    // randomized
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 15);
      issue(op, rnd_operand(), rnd_operand(), 1);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the lab datapath ALU, feeding the datapath's Z register pair (LO/HI).
- Single-cycle logic, arithmetic, shift and rotate ops, plus iterative signed Booth multiply (radix-2) and signed restoring divide.
- Handshake is start/busy/done so the control unit can stall on long ops.
- Width is generic.

Parameters:
- WIDTH, 32, operand width; even, >= 4.
- SHW, $clog2(WIDTH), shift/rotate amount width, taken from B[SHW-1:0].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch op; sampled only when busy=0
- cntrl  in  4  opcode, sampled with start
- A  in  WIDTH  operand A, sampled with start
- B  in  WIDTH  operand B, sampled with start
- C_LO  out  WIDTH  low result / quotient
- C_HI  out  WIDTH  high result / remainder
- busy  out  1  op in progress
- done  out  1  one-cycle pulse, results valid
- div_by_zero  out  1  set with done when DIV and B=0
- illegal_op  out  1  set with done for undefined opcode

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. Reset forces state IDLE, C_LO=C_HI=0, busy=0, done=0, div_by_zero=0, illegal_op=0. Reset beats start in the same cycle. Reset mid-operation aborts it; no done is produced.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB (A-B), 4 NEG (-B), 5 NOT (~B, bitwise).
  - 6 SHL (A<<B), 7 SRA (A>>>B, signed), 8 ROL A by B, 9 ROR A by B, 12 SHR (A>>B, logical).
  - 10 MUL, 11 DIV, 13-15 illegal.
- Shift/rotate amount: SHL/SRA/SHR/ROL/ROR use B[SHW-1:0] only. Amount 0 returns A.
- Width rules: ADD/SUB/NEG wrap modulo 2^WIDTH; no carry or overflow out. For all non-MUL/DIV ops, C_HI=0.
- States:
  - IDLE: busy=0.
    - start with opcode 0-9/12 -> result registered, done=1 next cycle, stay IDLE.
    - start with illegal opcode -> C_LO=C_HI=0, illegal_op=1, done next cycle.
    - start with MUL -> MUL.
    - start with DIV -> DIV if B!=0. If B=0: C_LO=all ones, C_HI=A, div_by_zero=1, done next cycle.
  - MUL: radix-2 Booth over {acc, Q, q-1}, one bit per cycle, WIDTH cycles. Then {C_HI,C_LO}= signed 2*WIDTH product, done=1, -> IDLE.
  - DIV: operands converted to magnitudes on entry. Restoring division, one bit per cycle, WIDTH cycles -> FIX.
  - FIX: apply signs. Quotient is truncated toward zero and goes to C_LO. Remainder takes the sign of the dividend and goes to C_HI. done=1, -> IDLE.
- Latency (start sampled at cycle 0):
  - single-cycle ops, illegal opcode and divide-by-zero: done at cycle 1.
  - MUL: done at cycle WIDTH+1.
  - DIV: done at cycle WIDTH+2.
- busy=1 from cycle 1 until the cycle before done; busy=0 in the done cycle.
- start while busy=1 is ignored; operands are not resampled.
- start in the done cycle is accepted (busy=0), giving back-to-back ops.
- Outputs hold their last values until the next done.
- div_by_zero and illegal_op are valid only with done and are cleared at the next accepted start.
- Corner cases: MUL of most-negative * most-negative gives the correct positive 2W-bit product. DIV of most-negative by -1: quotient wraps to most-negative, remainder 0.

Test Plan (WIDTH=32):
- MUL A=-7 (FFFFFFF9), B=3 -> at cycle 33: C_HI=FFFFFFFF, C_LO=FFFFFFEB, done pulse 1 cycle, busy low that cycle.
- DIV A=-7, B=2 -> at cycle 34: C_LO=FFFFFFFD (-3), C_HI=FFFFFFFF (-1). Also A=7, B=-2 -> C_LO=FFFFFFFD, C_HI=00000001.
- DIV A=5, B=0 -> cycle 1: C_LO=FFFFFFFF, C_HI=00000005, div_by_zero=1. Next start with ADD 2+3 -> C_LO=5, div_by_zero=0.
- ROL A=80000001, B=4 -> C_LO=00000018. ROR A=1, B=1 -> 80000000. SRA A=80000000, B=31 -> FFFFFFFF. SHL B=32 (amount 0) -> A unchanged.
- Start MUL, pulse start with DIV at cycle 5 -> ignored, MUL result at cycle 33. Then reset at cycle 10 of a DIV -> no done, all outputs 0, next ADD completes at cycle 1.
- Opcode 14 -> illegal_op=1, C_LO=C_HI=0. Back-to-back ADD accepted in the done cycle of a MUL -> second done exactly 1 cycle later.
